// File: rtl/logic_basic_queue_generic_reader.sv
// Read-side controller for the generic basic queue.
// Issues storage reads against a credit budget so that a small register FIFO
// (the output skid buffer) can absorb every read still in flight when the
// downstream consumer stalls, while sustaining one word per cycle at any
// storage read latency.
module logic_basic_queue_generic_reader #(
   parameter int DATA_WIDTH    = 1,
   parameter int ADDRESS_WIDTH = 1,
   parameter int READ_LATENCY  = 1
) (
   input  logic                     aclk,
   input  logic                     areset_n,
   input  logic                     tx_tready,
   output logic                     tx_tvalid,
   output logic [DATA_WIDTH-1:0]    tx_tdata,
   input  logic [DATA_WIDTH-1:0]    read_data,
   output logic [ADDRESS_WIDTH-1:0] read_pointer,
   output logic                     read_enable,
   input  logic [ADDRESS_WIDTH:0]   capacity,
   output logic                     idle
);

   // Skid buffer holds every in-flight read plus one word being presented
   // and one word landing in the same cycle.
   localparam int DEPTH = READ_LATENCY + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Number of set bits in the in-flight shift register.
   function automatic logic [CW-1:0] popcount(input logic [READ_LATENCY-1:0] v);
      logic [CW-1:0] sum;
      sum = {CW{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
         sum = sum + {{(CW-1){1'b0}}, v[i]};
      end
      return sum;
   endfunction

   // Buffer index increment, wrapping at DEPTH (DEPTH is not a power of two).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH - 1)) begin
         r = {PW{1'b0}};
      end else begin
         r = p + {{(PW-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   logic [ADDRESS_WIDTH-1:0] read_pointer_r;
   logic [READ_LATENCY-1:0]  in_flight_r;
   logic [READ_LATENCY-1:0]  in_flight_next_s;
   logic [DATA_WIDTH-1:0]    mem_r [DEPTH];
   logic [PW-1:0]            wr_ptr_r;
   logic [PW-1:0]            rd_ptr_r;
   logic [PW-1:0]            rd_ptr_next_s;
   logic [CW-1:0]            count_r;
   logic [CW-1:0]            count_next_s;
   logic [CW-1:0]            credits_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     read_enable_s;
   logic [DATA_WIDTH-1:0]    head_next_s;
   logic                     tx_tvalid_r;
   logic [DATA_WIDTH-1:0]    tx_tdata_r;
   logic                     idle_r;

   // Credit accounting, read strobe and next-state values of the skid buffer.
   always_comb begin
      credits_s     = DEPTH_C - (count_r + popcount(in_flight_r));
      read_enable_s = areset_n
                      && (capacity != {(ADDRESS_WIDTH+1){1'b0}})
                      && (credits_s != {CW{1'b0}});
      push_s        = in_flight_r[READ_LATENCY-1];
      pop_s         = tx_tvalid_r && tx_tready;

      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
         default: count_next_s = count_r;
      endcase

      if (pop_s) begin
         rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end

      in_flight_next_s    = {READ_LATENCY{1'b0}};
      in_flight_next_s[0] = read_enable_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
         in_flight_next_s[i] = in_flight_r[i-1];
      end

      // The landing word becomes the head only when nothing older remains.
      if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_next_s = read_data;
      end else begin
         head_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // Control state: pointers, occupancy, in-flight tracking and outputs.
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         read_pointer_r <= {ADDRESS_WIDTH{1'b0}};
         in_flight_r    <= {READ_LATENCY{1'b0}};
         wr_ptr_r       <= {PW{1'b0}};
         rd_ptr_r       <= {PW{1'b0}};
         count_r        <= {CW{1'b0}};
         tx_tvalid_r    <= 1'b0;
         tx_tdata_r     <= {DATA_WIDTH{1'b0}};
         idle_r         <= 1'b1;
      end else begin
         if (read_enable_s) begin
            read_pointer_r <= read_pointer_r + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
         end
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         in_flight_r <= in_flight_next_s;
         rd_ptr_r    <= rd_ptr_next_s;
         count_r     <= count_next_s;
         tx_tvalid_r <= (count_next_s != {CW{1'b0}});
         tx_tdata_r  <= head_next_s;
         idle_r      <= (count_next_s == {CW{1'b0}})
                        && (in_flight_next_s == {READ_LATENCY{1'b0}})
                        && (capacity == {{ADDRESS_WIDTH{1'b0}}, read_enable_s});
      end
   end

   // Skid buffer storage; data-path only, so it carries no reset.
   always_ff @(posedge aclk) begin
      if (areset_n && push_s) begin
         mem_r[wr_ptr_r] <= read_data;
      end
   end

   assign read_enable  = read_enable_s;
   assign read_pointer = read_pointer_r;
   assign tx_tvalid    = tx_tvalid_r;
   assign tx_tdata     = tx_tdata_r;
   assign idle         = idle_r;

endmodule

// File: tb/tb_logic_basic_queue_generic_reader.sv
// Directed bench for logic_basic_queue_generic_reader (READ_LATENCY=3,
// ADDRESS_WIDTH=4). The bench plays the queue wrapper and storage, and keeps
// a scoreboard of words written to storage, compared on every accepted beat.
module tb_logic_basic_queue_generic_reader;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int RL    = 3;
   localparam int DEPTH = RL + 2;

   logic          aclk = 1'b0;
   logic          areset_n;
   logic          tx_tready;
   logic          tx_tvalid;
   logic [DW-1:0] tx_tdata;
   logic [DW-1:0] read_data;
   logic [AW-1:0] read_pointer;
   logic          read_enable;
   logic [AW:0]   capacity;
   logic          idle;

   logic_basic_queue_generic_reader #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL)
   ) dut (
      .aclk(aclk), .areset_n(areset_n), .tx_tready(tx_tready),
      .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .read_data(read_data),
      .read_pointer(read_pointer), .read_enable(read_enable),
      .capacity(capacity), .idle(idle)
   );

   always #5 aclk = ~aclk;

   // storage / wrapper model
   logic [DW-1:0] mem [16];
   logic [DW-1:0] rd_pipe [RL];
   logic [RL-1:0] vld_pipe;
   logic [AW:0]   stored;
   logic [AW-1:0] wp;
   int            outst;
   logic          push_req;
   logic [DW-1:0] push_data;

   assign capacity  = stored;
   assign read_data = rd_pipe[RL-1];

   // Storage with RL-cycle read latency; its data pipe is deliberately not reset.
   always @(posedge aclk) begin
      rd_pipe[0] <= read_enable ? mem[read_pointer] : 8'hEE;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (!areset_n) begin
         stored   <= 5'd0;
         wp       <= 4'd0;
         outst    <= 0;
         vld_pipe <= 3'b000;
      end else begin
         if (push_req) begin
            mem[wp] <= push_data;
            wp      <= wp + 4'd1;
         end
         stored   <= stored + {4'd0, push_req} - {4'd0, read_enable};
         outst    <= outst + int'(read_enable) - int'(tx_tvalid && tx_tready);
         vld_pipe <= {vld_pipe[RL-2:0], read_enable};
      end
   end

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_q [$];
   int            seq = 0;
   int            cyc = 0;
   int            re_count = 0;
   int            acc_count = 0;
   int            first_re, first_v, first_acc, last_acc;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] held = 8'h00;
   logic          push_prev = 1'b0;
   logic          chk_idle = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check the state after the last edge, then drive the next.
   task automatic cycle(input logic rdy, input logic want_push);
      logic [DW-1:0] e;
      @(negedge aclk);
      if (stall_prev) begin
         check("hold_valid", {31'd0, tx_tvalid}, 32'd1);
         check("hold_data", {24'd0, tx_tdata}, {24'd0, held});
      end
      if (chk_idle && !push_prev)
         check("idle", {31'd0, idle}, {31'd0, exp_q.size() == 0});
      check("outstanding_le_depth", {31'd0, outst <= DEPTH}, 32'd1);
      tx_tready = rdy;
      push_req  = want_push && areset_n && (stored < 5'd16);
      if (push_req) begin
         push_data = seq[DW-1:0];
         exp_q.push_back(push_data);
         seq++;
      end
      push_prev = push_req;
      if (read_enable) re_count++;
      if (read_enable && first_re < 0) first_re = cyc;
      if (tx_tvalid && first_v < 0) first_v = cyc;
      if (tx_tvalid && rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", {24'd0, tx_tdata}, {24'd0, e});
         end
         acc_count++;
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
      end
      stall_prev = tx_tvalid && !rdy;
      held       = tx_tdata;
      cyc++;
   endtask

   initial begin
      int acc0, re0, seq0, inflight, buffered;
      logic found;
      areset_n  = 1'b0;
      tx_tready = 1'b0;
      push_req  = 1'b0;
      push_data = 8'h00;
      first_re = -1; first_v = -1; first_acc = -1; last_acc = -1;

      // reset values
      repeat (3) @(negedge aclk);
      check("rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
      check("rst_tdata", {24'd0, tx_tdata}, 32'd0);
      check("rst_rptr", {28'd0, read_pointer}, 32'd0);
      check("rst_idle", {31'd0, idle}, 32'd1);
      check("rst_renable", {31'd0, read_enable}, 32'd0);
      areset_n = 1'b1;

      // empty queue stays idle
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0);
         check("empty_renable", {31'd0, read_enable}, 32'd0);
         check("empty_tvalid", {31'd0, tx_tvalid}, 32'd0);
         check("empty_rptr", {28'd0, read_pointer}, 32'd0);
         check("empty_idle", {31'd0, idle}, 32'd1);
      end

      // streaming 20 words, pointer wraps
      first_re = -1; first_v = -1; first_acc = -1; acc0 = acc_count;
      for (int i = 0; i < 60; i++) cycle(1'b1, i < 20);
      check("first_latency", first_v - first_re, RL + 1);
      check("stream_beats", acc_count - acc0, 20);
      check("stream_back_to_back", last_acc - first_acc, 19);
      check("stream_rptr_end", {28'd0, read_pointer}, 32'd4);
      check("stream_empty_sb", exp_q.size(), 0);
      check("stream_idle", {31'd0, idle}, 32'd1);

      // backpressure: exactly DEPTH reads, head word held
      re0 = re_count; acc0 = acc_count;
      for (int i = 0; i < 18; i++) cycle(1'b0, i < 8);
      check("bp_reads", re_count - re0, DEPTH);
      check("bp_outstanding", outst, DEPTH);
      check("bp_tvalid", {31'd0, tx_tvalid}, 32'd1);
      check("bp_head", {24'd0, tx_tdata}, {24'd0, exp_q[0]});
      cycle(1'b1, 1'b0);
      check("bp_no_credit_yet", {31'd0, read_enable}, 32'd0);
      cycle(1'b1, 1'b0);
      check("bp_resume", {31'd0, read_enable}, 32'd1);
      for (int i = 0; i < 28; i++) cycle(1'b1, 1'b0);
      check("bp_drained", acc_count - acc0, 8);
      check("bp_empty_sb", exp_q.size(), 0);

      // random ready, 1000 words
      acc0 = acc_count; seq0 = seq;
      for (int k = 0; k < 20000; k++) begin
         if (seq - seq0 >= 1000 && exp_q.size() == 0) break;
         cycle(logic'($urandom_range(1, 0)), (seq - seq0) < 1000);
      end
      check("rand_words", acc_count - acc0, 1000);
      check("rand_empty_sb", exp_q.size(), 0);

      // reset with 2 reads in flight and 3 words buffered
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         inflight = $countones(vld_pipe);
         buffered = outst - inflight;
         if (inflight == 2 && buffered == 3) begin
            found = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1);
      end
      check("mid_state_reached", {31'd0, found}, 32'd1);
      areset_n = 1'b0; push_req = 1'b0; tx_tready = 1'b0;
      exp_q.delete(); stall_prev = 1'b0; push_prev = 1'b0;
      @(negedge aclk);
      check("mid_rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
      check("mid_rst_rptr", {28'd0, read_pointer}, 32'd0);
      check("mid_rst_idle", {31'd0, idle}, 32'd1);
      check("mid_rst_renable", {31'd0, read_enable}, 32'd0);
      areset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0);
         check("no_stale_push", {31'd0, tx_tvalid}, 32'd0);
      end

      // trickle: capacity alternates 0/1
      chk_idle = 1'b1; re0 = re_count; acc0 = acc_count;
      for (int i = 0; i < 30; i++) cycle(1'b1, (i % 2 == 0) && (i < 20));
      chk_idle = 1'b0;
      check("trickle_reads", re_count - re0, 10);
      check("trickle_words", acc_count - acc0, 10);
      check("trickle_empty_sb", exp_q.size(), 0);
      check("trickle_idle", {31'd0, idle}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
